// File: rtl/op_pkg.sv
// Shared constants for the operation sequencer: order codes, memory select
// codes, arithmetic order bit positions and the one-hot state encoding.
package op_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DIV    = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_CMP    = 4'd5;
  localparam logic [3:0] OP_ABSADD = 4'd6;
  localparam logic [3:0] OP_ABSSUB = 4'd7;

  localparam logic [1:0] SEL_IDLE = 2'b00;
  localparam logic [1:0] SEL_OP1  = 2'b01;
  localparam logic [1:0] SEL_OP2  = 2'b10;
  localparam logic [1:0] SEL_RES  = 2'b11;

  // Bit positions inside the order vector sent to arithmetic control.
  localparam int ORD_ADD = 0;
  localparam int ORD_SUB = 1;
  localparam int ORD_MUL = 2;
  localparam int ORD_DIV = 3;
  localparam int ORD_AND = 4;
  localparam int ORD_W   = 5;

  localparam int S_IDLE    = 0;
  localparam int S_CLR     = 1;
  localparam int S_RD1     = 2;
  localparam int S_MV_A    = 3;
  localparam int S_RD2     = 4;
  localparam int S_MV_B    = 5;
  localparam int S_ISSUE   = 6;
  localparam int S_WAIT_AC = 7;
  localparam int S_WR      = 8;
  localparam int S_DONE    = 9;
  localparam int N_STATES  = 10;

  typedef enum logic [N_STATES-1:0] {
    ST_IDLE    = N_STATES'(1) << S_IDLE,
    ST_CLR     = N_STATES'(1) << S_CLR,
    ST_RD1     = N_STATES'(1) << S_RD1,
    ST_MV_A    = N_STATES'(1) << S_MV_A,
    ST_RD2     = N_STATES'(1) << S_RD2,
    ST_MV_B    = N_STATES'(1) << S_MV_B,
    ST_ISSUE   = N_STATES'(1) << S_ISSUE,
    ST_WAIT_AC = N_STATES'(1) << S_WAIT_AC,
    ST_WR      = N_STATES'(1) << S_WR,
    ST_DONE    = N_STATES'(1) << S_DONE
  } state_t;

  typedef struct packed {
    logic [ORD_W-1:0] order;
    logic             abs;
    logic             cmp;
    logic             legal;
  } dec_t;

endpackage

// File: rtl/op_seq_if.sv
// Memory port of the operation sequencer: read/write requests with an
// address select, completed by a single-cycle acknowledge from memory.
interface op_seq_if;
  logic       mem_rd_req_to_mem;
  logic       mem_wr_req_to_mem;
  logic [1:0] mem_sel_to_mem;
  logic       mem_ack_from_mem;

  modport master (
    output mem_rd_req_to_mem, mem_wr_req_to_mem, mem_sel_to_mem,
    input  mem_ack_from_mem
  );

  modport slave (
    input  mem_rd_req_to_mem, mem_wr_req_to_mem, mem_sel_to_mem,
    output mem_ack_from_mem
  );
endinterface

// File: rtl/op_seq_decode.sv
// Order decoder: maps a 4-bit order code to the arithmetic order vector and
// the abs/cmp/legal qualifiers.
module op_seq_decode
  import op_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    dec       = '0;
    dec.legal = 1'b1;
    case (opcode)
      OP_ADD:    dec.order[ORD_ADD] = 1'b1;
      OP_SUB:    dec.order[ORD_SUB] = 1'b1;
      OP_MUL:    dec.order[ORD_MUL] = 1'b1;
      OP_DIV:    dec.order[ORD_DIV] = 1'b1;
      OP_AND:    dec.order[ORD_AND] = 1'b1;
      OP_CMP: begin
        dec.order[ORD_SUB] = 1'b1;
        dec.cmp            = 1'b1;
      end
      OP_ABSADD: begin
        dec.order[ORD_ADD] = 1'b1;
        dec.abs            = 1'b1;
      end
      OP_ABSSUB: begin
        dec.order[ORD_SUB] = 1'b1;
        dec.abs            = 1'b1;
      end
      default:   dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/op_seq.sv
// Operation sequencer: fetches two operands into A and B through C, fires one
// arithmetic order, waits for the answer under a watchdog, optionally stores.
module op_seq
  import op_pkg::*;
#(
  parameter int TIMEOUT = 127,
  parameter int TO_W    = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_from_pu,
  input  logic [3:0] opcode_from_pu,
  input  logic       store_from_pu,
  op_seq_if.master   mem,
  input  logic       ac_answer_from_ac,
  input  logic       reg_b_sign_from_ac,
  output logic       do_clear_a_to_ac,
  output logic       do_mem_to_c_to_ac,
  output logic       do_move_c_to_a_to_ac,
  output logic       do_move_c_to_b_to_ac,
  output logic       order_add_to_ac,
  output logic       order_sub_to_ac,
  output logic       order_mul_to_ac,
  output logic       order_div_to_ac,
  output logic       order_and_to_ac,
  output logic       ctrl_abs_to_ac,
  output logic       busy_to_pu,
  output logic       done_to_pu,
  output logic       branch_to_pu,
  output logic       err_illegal_to_pu,
  output logic       err_timeout_to_pu
);

  state_t           state, state_nxt;
  dec_t             dec;
  logic [ORD_W-1:0] order_q, order_pulse;
  logic             store_q, abs_q, cmp_q, branch_q;
  logic             err_ill_q, err_to_q;
  logic [TO_W-1:0]  wd;
  logic             wd_hit, accept, rd_req, wr_req;
  logic [1:0]       sel;

  op_seq_decode u_decode (
    .opcode (opcode_from_pu),
    .dec    (dec)
  );

  assign accept = (state == ST_IDLE) && start_from_pu && dec.legal;
  assign wd_hit = (wd == TO_W'(TIMEOUT));

  always_comb begin
    state_nxt            = state;
    rd_req               = 1'b0;
    wr_req               = 1'b0;
    sel                  = SEL_IDLE;
    do_clear_a_to_ac     = 1'b0;
    do_mem_to_c_to_ac    = 1'b0;
    do_move_c_to_a_to_ac = 1'b0;
    do_move_c_to_b_to_ac = 1'b0;
    order_pulse          = '0;
    ctrl_abs_to_ac       = 1'b0;
    done_to_pu           = 1'b0;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_CLR;
      ST_CLR: begin
        do_clear_a_to_ac = 1'b1;
        state_nxt        = ST_RD1;
      end
      ST_RD1: begin
        rd_req = 1'b1;
        sel    = SEL_OP1;
        if (mem.mem_ack_from_mem) begin
          do_mem_to_c_to_ac = 1'b1;
          state_nxt         = ST_MV_A;
        end
      end
      ST_MV_A: begin
        do_move_c_to_a_to_ac = 1'b1;
        ctrl_abs_to_ac       = abs_q;
        state_nxt            = ST_RD2;
      end
      ST_RD2: begin
        rd_req = 1'b1;
        sel    = SEL_OP2;
        if (mem.mem_ack_from_mem) begin
          do_mem_to_c_to_ac = 1'b1;
          state_nxt         = ST_MV_B;
        end
      end
      ST_MV_B: begin
        do_move_c_to_b_to_ac = 1'b1;
        ctrl_abs_to_ac       = abs_q;
        state_nxt            = ST_ISSUE;
      end
      ST_ISSUE: begin
        order_pulse = order_q;
        state_nxt   = ST_WAIT_AC;
      end
      // The answer takes priority over a watchdog expiring in the same cycle.
      ST_WAIT_AC: begin
        if (ac_answer_from_ac) state_nxt = store_q ? ST_WR : ST_DONE;
        else if (wd_hit)       state_nxt = ST_IDLE;
      end
      ST_WR: begin
        wr_req = 1'b1;
        sel    = SEL_RES;
        if (mem.mem_ack_from_mem) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_to_pu = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      order_q   <= '0;
      store_q   <= 1'b0;
      abs_q     <= 1'b0;
      cmp_q     <= 1'b0;
      branch_q  <= 1'b0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
      wd        <= '0;
    end else begin
      state     <= state_nxt;
      err_ill_q <= (state == ST_IDLE) && start_from_pu && !dec.legal;
      err_to_q  <= (state == ST_WAIT_AC) && !ac_answer_from_ac && wd_hit;
      if (accept) begin
        order_q <= dec.order;
        store_q <= store_from_pu && !dec.cmp;
        abs_q   <= dec.abs;
        cmp_q   <= dec.cmp;
        if (dec.cmp) branch_q <= 1'b0;
      end
      if (state == ST_ISSUE)        wd <= '0;
      else if (state == ST_WAIT_AC) wd <= wd + TO_W'(1);
      if ((state == ST_WAIT_AC) && ac_answer_from_ac && cmp_q)
        branch_q <= reg_b_sign_from_ac;
    end
  end

  assign mem.mem_rd_req_to_mem = rd_req;
  assign mem.mem_wr_req_to_mem = wr_req;
  assign mem.mem_sel_to_mem    = sel;

  assign order_add_to_ac   = order_pulse[ORD_ADD];
  assign order_sub_to_ac   = order_pulse[ORD_SUB];
  assign order_mul_to_ac   = order_pulse[ORD_MUL];
  assign order_div_to_ac   = order_pulse[ORD_DIV];
  assign order_and_to_ac   = order_pulse[ORD_AND];
  assign busy_to_pu        = (state != ST_IDLE);
  assign branch_to_pu      = branch_q;
  assign err_illegal_to_pu = err_ill_q;
  assign err_timeout_to_pu = err_to_q;

endmodule
